// File: rtl/cond_resolve_unit.sv
// Branch/trap condition resolver: holds NCC condition-code sets, evaluates IR[31:25]
// requests over valid/ready and returns registered BCOND/TCOND/ANNUL results.
module cond_resolve_unit #(
  parameter int NCC    = 2,
  parameter bit FWD_EN = 1'b1,
  parameter int SELW   = ($clog2(NCC) > 0) ? $clog2(NCC) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cc_we,
  input  logic [SELW-1:0] cc_wsel,
  input  logic [3:0]      cc_wdata,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      req_ir,
  input  logic [SELW-1:0] req_ccsel,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_bcond,
  output logic            res_tcond,
  output logic            res_annul,
  input  logic            trap_ack,
  output logic            trap_busy
);

  typedef enum logic [1:0] {IDLE, FULL, TRAP_WAIT} state_t;

  localparam logic [SELW:0] NCC_W = (SELW+1)'(NCC);

  state_t          state_q, state_d;
  logic [3:0]      cc_q [NCC];
  logic [3:0]      cc_stored, flags;
  logic [SELW-1:0] eval_sel;
  logic            cc_wsel_ok, ccsel_ok, fwd_hit;
  logic [1:0]      op;
  logic            annul_bit;
  logic [3:0]      cond;
  logic            cond_base, cond_true;
  logic            new_b, new_t, new_a;
  logic            load, clear;

  assign op        = req_ir[6:5];
  assign annul_bit = req_ir[4];
  assign cond      = req_ir[3:0];

  assign cc_wsel_ok = ({1'b0, cc_wsel} < NCC_W);
  assign ccsel_ok   = ({1'b0, req_ccsel} < NCC_W);
  assign eval_sel   = ccsel_ok ? req_ccsel : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCC; i++) cc_q[i] <= '0;
    end else if (cc_we) begin
      for (int unsigned i = 0; i < NCC; i++)
        if (cc_wsel == SELW'(i)) cc_q[i] <= cc_wdata;
    end
  end

  always_comb begin
    cc_stored = '0;
    for (int unsigned i = 0; i < NCC; i++)
      if (eval_sel == SELW'(i)) cc_stored = cc_q[i];
  end

  // Forward only a write that will actually land in the set being tested.
  assign fwd_hit = FWD_EN && cc_we && cc_wsel_ok && (cc_wsel == eval_sel);
  assign flags   = fwd_hit ? cc_wdata : cc_stored;

  // flags = {N,Z,V,C}; cond[3] inverts the base test, so 1000 is "always".
  always_comb begin
    cond_base = 1'b0;
    unique case (cond[2:0])
      3'b000: cond_base = 1'b0;
      3'b001: cond_base = flags[2];
      3'b010: cond_base = flags[2] | (flags[3] ^ flags[1]);
      3'b011: cond_base = flags[3] ^ flags[1];
      3'b100: cond_base = flags[0] | flags[2];
      3'b101: cond_base = flags[0];
      3'b110: cond_base = flags[3];
      3'b111: cond_base = flags[1];
      default: cond_base = 1'b0;
    endcase
    cond_true = cond[3] ^ cond_base;
  end

  always_comb begin
    new_b = 1'b0;
    new_t = 1'b0;
    new_a = 1'b0;
    case (op)
      2'b00: begin
        new_b = cond_true;
        new_a = annul_bit & (!cond_true | (cond == 4'b1000));
      end
      2'b10: new_t = cond_true;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = FULL;
          load    = 1'b1;
        end
      end
      FULL: begin
        if (res_ready) begin
          if (res_tcond) begin
            state_d = TRAP_WAIT;
            clear   = 1'b1;
          end else begin
            req_ready = 1'b1;
            if (req_valid) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              clear   = 1'b1;
            end
          end
        end
      end
      TRAP_WAIT: begin
        if (trap_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      res_bcond <= 1'b0;
      res_tcond <= 1'b0;
      res_annul <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        res_bcond <= new_b;
        res_tcond <= new_t;
        res_annul <= new_a;
      end else if (clear) begin
        res_bcond <= 1'b0;
        res_tcond <= 1'b0;
        res_annul <= 1'b0;
      end
    end
  end

  assign res_valid = (state_q == FULL);
  assign trap_busy = (state_q == TRAP_WAIT);

endmodule

// File: tb/tb_cond_resolve_unit.sv
// Scoreboard bench for cond_resolve_unit: directed requests push expected
// {bcond,tcond,annul}; a negedge monitor compares whatever the DUT presents.
module tb_cond_resolve_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cc_we;
  logic [0:0] cc_wsel;
  logic [3:0] cc_wdata;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_ir;
  logic [0:0] req_ccsel;
  logic       res_valid, res_ready, res_bcond, res_tcond, res_annul;
  logic       trap_ack, trap_busy;

  logic nf_req_ready, nf_res_valid, nf_bcond, nf_tcond, nf_annul, nf_trap_busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] sb[$];

  always #5 clk = ~clk;

  cond_resolve_unit #(.NCC(2), .FWD_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cc_we(cc_we), .cc_wsel(cc_wsel), .cc_wdata(cc_wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_ir(req_ir), .req_ccsel(req_ccsel),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_bcond(res_bcond), .res_tcond(res_tcond), .res_annul(res_annul),
    .trap_ack(trap_ack), .trap_busy(trap_busy)
  );

  cond_resolve_unit #(.NCC(2), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst_n(rst_n),
    .cc_we(cc_we), .cc_wsel(cc_wsel), .cc_wdata(cc_wdata),
    .req_valid(req_valid), .req_ready(nf_req_ready), .req_ir(req_ir), .req_ccsel(req_ccsel),
    .res_valid(nf_res_valid), .res_ready(res_ready),
    .res_bcond(nf_bcond), .res_tcond(nf_tcond), .res_annul(nf_annul),
    .trap_ack(trap_ack), .trap_busy(nf_trap_busy)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitor: every presented result must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %b%b%b expected none at %0t",
                 res_bcond, res_tcond, res_annul, $time);
      end else begin
        check("result_bta", {1'b0, res_bcond, res_tcond, res_annul}, {1'b0, sb[0]});
        if (res_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_cc(input logic sel, input logic [3:0] data);
    cc_we = 1'b1; cc_wsel = sel; cc_wdata = data;
    @(posedge clk);
    #1;
    cc_we = 1'b0;
  endtask

  task automatic issue(input logic [6:0] ir, input logic sel, input logic [2:0] exp);
    int unsigned waited = 0;
    bit done = 1'b0;
    req_valid = 1'b1; req_ir = ir; req_ccsel = sel;
    while (!done && waited < 50) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back(exp);
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("accept_in_time", {3'b0, done}, 4'h1);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_valid"}, {3'b0, res_valid}, 4'h0);
    check({name, "_bta"}, {1'b0, res_bcond, res_tcond, res_annul}, 4'h0);
    check({name, "_busy"}, {3'b0, trap_busy}, 4'h0);
    check({name, "_ready"}, {3'b0, req_ready}, 4'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cc_we = 1'b0; cc_wsel = '0; cc_wdata = '0;
    req_valid = 1'b0; req_ir = '0; req_ccsel = '0;
    res_ready = 1'b1; trap_ack = 1'b0;
    #2;
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Basic branch evaluation
    write_cc(1'b0, 4'b0100);
    issue(7'b0000001, 1'b0, 3'b100);   // be, Z=1
    write_cc(1'b0, 4'b0000);
    issue(7'b0010001, 1'b0, 3'b001);   // be,a not taken -> annul
    issue(7'b0011000, 1'b0, 3'b101);   // ba,a -> taken and annul
    issue(7'b0101000, 1'b0, 3'b000);   // op=01 -> all zero
    write_cc(1'b0, 4'b1000);           // N=1 V=0
    issue(7'b0000011, 1'b0, 3'b100);   // bl
    issue(7'b0010011, 1'b0, 3'b100);   // bl,a taken -> no annul
    issue(7'b0011011, 1'b0, 3'b001);   // bge,a not taken -> annul
    issue(7'b1000000, 1'b0, 3'b000);   // tn -> no trap
    write_cc(1'b0, 4'b0101);           // Z,C
    issue(7'b0000100, 1'b0, 3'b100);   // bleu
    issue(7'b0001100, 1'b0, 3'b000);   // bgu
    issue(7'b0001101, 1'b0, 3'b000);   // bcc
    write_cc(1'b0, 4'b0010);           // V
    issue(7'b0000111, 1'b0, 3'b100);   // bvs
    issue(7'b0001111, 1'b0, 3'b000);   // bvc

    // Same-cycle flag write forwarding into set 1
    idle(2);
    cc_we = 1'b1; cc_wsel = 1'b1; cc_wdata = 4'b0001;
    issue(7'b0000101, 1'b1, 3'b100);   // bcs on set 1
    cc_we = 1'b0;
    check("nofwd_bcond", {3'b0, nf_bcond}, 4'h0);
    issue(7'b0000101, 1'b1, 3'b100);
    check("nofwd_stored_bcond", {3'b0, nf_bcond}, 4'h1);

    // Trap taken: stall until acknowledged
    idle(2);
    write_cc(1'b0, 4'b1000);
    issue(7'b1000011, 1'b0, 3'b010);   // tl
    check("trap_full_ready", {3'b0, req_ready}, 4'h0);
    idle(1);
    check("trapwait_busy", {3'b0, trap_busy}, 4'h1);
    check("trapwait_valid", {3'b0, res_valid}, 4'h0);
    check("trapwait_tcond", {3'b0, res_tcond}, 4'h0);
    req_valid = 1'b1; req_ir = 7'b0001000; req_ccsel = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("trapwait_ready", {3'b0, req_ready}, 4'h0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    trap_ack = 1'b1; cc_we = 1'b1; cc_wsel = 1'b0; cc_wdata = 4'b0100;
    @(posedge clk);
    #1;
    trap_ack = 1'b0; cc_we = 1'b0;
    check("post_ack_ready", {3'b0, req_ready}, 4'h1);
    check("post_ack_busy", {3'b0, trap_busy}, 4'h0);
    trap_ack = 1'b1;
    idle(1);
    trap_ack = 1'b0;
    check("idle_ack_busy", {3'b0, trap_busy}, 4'h0);
    issue(7'b0000001, 1'b0, 3'b100);   // be sees write made with the ack
    idle(2);

    // Consumer back-pressure with a request waiting
    res_ready = 1'b0;
    issue(7'b0000001, 1'b0, 3'b100);
    req_valid = 1'b1; req_ir = 7'b0001001; req_ccsel = 1'b0;   // bne, Z=1
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", {3'b0, req_ready}, 4'h0);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("release_ready", {3'b0, req_ready}, 4'h1);
    sb.push_back(3'b000);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    idle(2);

    // Reset while waiting for trap acknowledge
    issue(7'b1011000, 1'b0, 3'b010);   // ta,a -> trap, no annul
    idle(1);
    check("pre_reset_busy", {3'b0, trap_busy}, 4'h1);
    rst_n = 1'b0;
    #1;
    check_quiet("reset_trapwait");
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // Reset with a result pending
    write_cc(1'b0, 4'b0100);
    res_ready = 1'b0;
    issue(7'b0000001, 1'b0, 3'b100);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_quiet("reset_full");
    idle(1);
    rst_n = 1'b1;
    res_ready = 1'b1;
    idle(1);
    issue(7'b0000001, 1'b0, 3'b000);   // set 0 cleared -> Z=0
    issue(7'b0000101, 1'b1, 3'b000);   // set 1 cleared -> C=0
    idle(3);
    check("scoreboard_drained", 4'(sb.size()), 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
